// File: rtl/video_frame_rx_pkg.sv
// Shared types and constants for the video frame receiver.
// Holds the FSM encoding, control-word field offsets and the default geometry limit.
package video_frame_rx_pkg;

    typedef enum logic {
        WAIT_CTRL = 1'b0,
        ACTIVE    = 1'b1
    } state_t;

    localparam int CTRL_W     = 36;
    localparam int WIDTH_MSB  = 35;
    localparam int WIDTH_LSB  = 20;
    localparam int HEIGHT_MSB = 19;
    localparam int HEIGHT_LSB = 4;
    localparam int PAD_MSB    = 3;
    localparam int PAD_LSB    = 0;

    localparam logic [15:0] MAX_DIM = 16'd4096;

    // A control word is usable only with non-zero, in-range
    // dimensions and a zero pad nibble.
    function automatic logic ctrl_ok(
        input logic [CTRL_W-1:0] word,
        input logic [15:0]       max_dim
    );
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  pad;
        w   = word[WIDTH_MSB:WIDTH_LSB];
        h   = word[HEIGHT_MSB:HEIGHT_LSB];
        pad = word[PAD_MSB:PAD_LSB];
        return (w != 16'd0) && (h != 16'd0) &&
               (w <= max_dim) && (h <= max_dim) &&
               (pad == 4'h0);
    endfunction

endpackage

// File: rtl/video_frame_rx_if.sv
// Bundle of the control, sink and source stream signals of video_frame_rx.
// master: traffic generator / downstream side; slave: the receiver itself.
interface video_frame_rx_if #(
    parameter int DW = 8
);
    logic [35:0]   ctrl_in_data;
    logic          ctrl_in_valid;

    logic [DW-1:0] sink_video_data;
    logic          sink_video_valid;
    logic          sink_video_ready;

    logic [DW-1:0] source_video_data;
    logic          source_video_valid;
    logic          source_video_ready;
    logic          source_sof;
    logic          source_eol;
    logic          source_eof;

    modport master (
        output ctrl_in_data,
        output ctrl_in_valid,
        output sink_video_data,
        output sink_video_valid,
        input  sink_video_ready,
        input  source_video_data,
        input  source_video_valid,
        output source_video_ready,
        input  source_sof,
        input  source_eol,
        input  source_eof
    );

    modport slave (
        input  ctrl_in_data,
        input  ctrl_in_valid,
        input  sink_video_data,
        input  sink_video_valid,
        output sink_video_ready,
        output source_video_data,
        output source_video_valid,
        input  source_video_ready,
        output source_sof,
        output source_eol,
        output source_eof
    );
endinterface

// File: rtl/video_frame_rx_raster_cnt.sv
// Raster position counter: x runs 0..width-1, y runs 0..height-1.
// Ports: clk, rst, en (advance), width, height -> x, y, sof, eol, eof.
module raster_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] width,
    input  logic [15:0] height,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        sof,
    output logic        eol,
    output logic        eof
);

    assign sof = (x == 16'd0) && (y == 16'd0);
    assign eol = (x == width - 16'd1);
    assign eof = eol && (y == height - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= 16'd0;
            y <= 16'd0;
        end else if (en) begin
            if (eol) begin
                x <= 16'd0;
                y <= eof ? 16'd0 : y + 16'd1;
            end else begin
                x <= x + 16'd1;
            end
        end
    end

endmodule

// File: rtl/video_frame_rx.sv
// Video frame receiver: tags a raster pixel stream with sof/eol/eof.
// Ports: clk, rst, bus (ctrl/sink/source streams), frame_done, err_ctrl,
// err_early_ctrl, frame_count, busy.
module video_frame_rx
    import video_frame_rx_pkg::*;
#(
    parameter int          DW      = 8,
    parameter logic [15:0] MAX_DIM = video_frame_rx_pkg::MAX_DIM
) (
    input  logic               clk,
    input  logic               rst,
    video_frame_rx_if.slave    bus,
    output logic               frame_done,
    output logic               err_ctrl,
    output logic               err_early_ctrl,
    output logic [15:0]        frame_count,
    output logic               busy
);

    state_t        state_q;
    state_t        state_d;

    logic [15:0]   width_q;
    logic [15:0]   height_q;
    logic          pend_q;
    logic [15:0]   pend_w_q;
    logic [15:0]   pend_h_q;

    logic [DW-1:0] src_data_q;
    logic          src_valid_q;
    logic          sof_q;
    logic          eol_q;
    logic          eof_q;

    logic [15:0]   ctrl_w;
    logic [15:0]   ctrl_h;
    logic          ctrl_good;
    logic          ctrl_bad;
    logic          sink_ready;
    logic          accept;
    logic          at_origin;

    logic [15:0]   x;
    logic [15:0]   y;
    logic          sof;
    logic          eol;
    logic          eof;

    logic          geo_ld;
    logic [15:0]   geo_w;
    logic [15:0]   geo_h;
    logic          pend_set;
    logic          pend_clr;
    logic          early;

    assign ctrl_w    = bus.ctrl_in_data[WIDTH_MSB:WIDTH_LSB];
    assign ctrl_h    = bus.ctrl_in_data[HEIGHT_MSB:HEIGHT_LSB];
    assign ctrl_good = bus.ctrl_in_valid &&  ctrl_ok(bus.ctrl_in_data, MAX_DIM);
    assign ctrl_bad  = bus.ctrl_in_valid && !ctrl_ok(bus.ctrl_in_data, MAX_DIM);

    // The output register can take a new pixel when it is empty
    // or being drained this cycle.
    assign sink_ready = (state_q == ACTIVE) &&
                        (!src_valid_q || bus.source_video_ready);
    assign accept     = bus.sink_video_valid && sink_ready;
    assign at_origin  = (x == 16'd0) && (y == 16'd0);

    assign bus.sink_video_ready   = sink_ready;
    assign bus.source_video_data  = src_data_q;
    assign bus.source_video_valid = src_valid_q;
    assign bus.source_sof         = sof_q;
    assign bus.source_eol         = eol_q;
    assign bus.source_eof         = eof_q;
    assign busy                   = (state_q == ACTIVE);

    raster_cnt u_raster_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (accept),
        .width  (width_q),
        .height (height_q),
        .x      (x),
        .y      (y),
        .sof    (sof),
        .eol    (eol),
        .eof    (eof)
    );

    always_comb begin
        state_d  = state_q;
        geo_ld   = 1'b0;
        geo_w    = width_q;
        geo_h    = height_q;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        early    = 1'b0;
        unique case (state_q)
            WAIT_CTRL: begin
                if (ctrl_good) begin
                    state_d = ACTIVE;
                    geo_ld  = 1'b1;
                    geo_w   = ctrl_w;
                    geo_h   = ctrl_h;
                end
            end
            ACTIVE: begin
                // A word arriving with the closing pixel is newer
                // than any pending one, so it wins for the next frame.
                if (accept && eof) begin
                    if (ctrl_good) begin
                        geo_ld   = 1'b1;
                        geo_w    = ctrl_w;
                        geo_h    = ctrl_h;
                        pend_clr = 1'b1;
                    end else if (pend_q) begin
                        geo_ld   = 1'b1;
                        geo_w    = pend_w_q;
                        geo_h    = pend_h_q;
                        pend_clr = 1'b1;
                    end
                end else if (ctrl_good) begin
                    if (at_origin && !accept) begin
                        geo_ld   = 1'b1;
                        geo_w    = ctrl_w;
                        geo_h    = ctrl_h;
                        pend_clr = 1'b1;
                    end else begin
                        early    = 1'b1;
                        pend_set = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_CTRL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_CTRL;
            width_q  <= 16'd0;
            height_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (geo_ld) begin
                width_q  <= geo_w;
                height_q <= geo_h;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= 1'b0;
            pend_w_q <= 16'd0;
            pend_h_q <= 16'd0;
        end else if (pend_set) begin
            pend_q   <= 1'b1;
            pend_w_q <= ctrl_w;
            pend_h_q <= ctrl_h;
        end else if (pend_clr) begin
            pend_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_data_q  <= '0;
            src_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else if (accept) begin
            src_data_q  <= bus.sink_video_data;
            src_valid_q <= 1'b1;
            sof_q       <= sof;
            eol_q       <= eol;
            eof_q       <= eof;
        end else if (bus.source_video_ready) begin
            src_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done     <= 1'b0;
            err_ctrl       <= 1'b0;
            err_early_ctrl <= 1'b0;
            frame_count    <= 16'd0;
        end else begin
            frame_done     <= accept && eof;
            err_ctrl       <= ctrl_bad;
            err_early_ctrl <= early;
            if (accept && eof) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
